// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared types and constants for the I2S receive deserializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int DEF_SAMPLE_WIDTH = 16;
    localparam int DEF_CNT_WIDTH    = 6;

    // Word-select level that marks each channel's slot.
    localparam int LEFT_CH  = 0;
    localparam int RIGHT_CH = 1;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pin_sync
//  Description : Two-flop synchronizers for SCK/WS/SD plus SCK rising-edge detect.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_sck,
    input  logic i_ws,
    input  logic i_sd,
    output logic o_sck_rise,
    output logic o_ws,
    output logic o_sd
);

    // Bit order in the vectors: [2]=sd, [1]=ws, [0]=sck
    logic [2:0] r_s1;
    logic [2:0] r_s2;
    logic       r_sck_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_sck_s3 <= 1'b0;
        end else begin
            r_s1     <= {i_sd, i_ws, i_sck};
            r_s2     <= r_s1;
            r_sck_s3 <= r_s2[0];
        end
    end

    assign o_sck_rise = r_s2[0] & ~r_sck_s3;
    assign o_ws       = r_s2[1];
    assign o_sd       = r_s2[2];

endmodule : i2s_pin_sync
`default_nettype wire

// File: rtl/i2s_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_deser
//  Description : I2S receiver; oversamples SCK/WS/SD and emits {left,right} pairs
//                on a ready/valid port feeding the input FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_deser
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int DATA_SIZE    = 2 * DEF_SAMPLE_WIDTH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 i2s_sck,
    input  logic                 i2s_ws,
    input  logic                 i2s_sd,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_rts,
    input  logic                 out_rtr,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    localparam logic c_ws_left  = 1'(LEFT_CH);
    localparam logic c_ws_right = 1'(RIGHT_CH);

    logic                    w_rise;
    logic                    w_ws;
    logic                    w_sd;
    logic                    w_trans;

    i2s_state_t              r_state;
    i2s_state_t              w_state_nxt;
    logic                    w_left_load;
    logic                    w_pair_load;

    logic                    r_ws_prev;
    logic [CNT_WIDTH-1:0]    r_bit_cnt;
    logic [SAMPLE_WIDTH-1:0] r_shreg;
    logic [SAMPLE_WIDTH-1:0] w_shreg_done;
    logic [SAMPLE_WIDTH-1:0] r_left_hold;
    logic [DATA_SIZE-1:0]    r_pair;
    logic                    r_pair_vld;

    logic [DATA_SIZE-1:0]    r_out_data;
    logic                    r_out_rts;
    logic                    r_ovf;
    logic                    w_xfer;
    logic                    w_ovf_set;

    i2s_pin_sync u_pin_sync (
        .clk        (clk),
        .rst        (rst),
        .i_sck      (i2s_sck),
        .i_ws       (i2s_ws),
        .i_sd       (i2s_sd),
        .o_sck_rise (w_rise),
        .o_ws       (w_ws),
        .o_sd       (w_sd)
    );

    assign w_trans = (w_ws != r_ws_prev);

    // Slot contents including the bit on this rise; bits past SAMPLE_WIDTH are dropped.
    always_comb begin
        w_shreg_done = r_shreg;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            if (r_bit_cnt == CNT_WIDTH'(SAMPLE_WIDTH - 1 - i)) begin
                w_shreg_done[i] = w_sd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_left_load = 1'b0;
        w_pair_load = 1'b0;
        if (!en) begin
            w_state_nxt = SYNC;
        end else if (w_rise && w_trans) begin
            case (r_state)
                SYNC: begin
                    if (w_ws == c_ws_left) begin
                        w_state_nxt = LEFT;
                    end
                end
                LEFT: begin
                    if (w_ws == c_ws_right) begin
                        w_left_load = 1'b1;
                        w_state_nxt = RIGHT;
                    end
                end
                RIGHT: begin
                    if (w_ws == c_ws_left) begin
                        w_pair_load = 1'b1;
                        w_state_nxt = LEFT;
                    end
                end
                default: w_state_nxt = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ws_prev   <= 1'b0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_left_hold <= '0;
            r_pair      <= '0;
            r_pair_vld  <= 1'b0;
        end else begin
            r_pair_vld <= w_pair_load;
            if (w_pair_load) begin
                r_pair <= {r_left_hold, w_shreg_done};
            end
            if (w_left_load) begin
                r_left_hold <= w_shreg_done;
            end
            if (w_rise) begin
                r_ws_prev <= w_ws;
            end
            if (!en) begin
                r_bit_cnt <= '0;
                r_shreg   <= '0;
            end else if (w_rise) begin
                // The transition rise closes the old slot; the next rise is bit 0.
                if (w_trans) begin
                    r_bit_cnt <= '0;
                    r_shreg   <= '0;
                end else begin
                    r_shreg <= w_shreg_done;
                    if (r_bit_cnt != {CNT_WIDTH{1'b1}}) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign w_xfer    = r_out_rts && out_rtr;
    assign w_ovf_set = r_pair_vld && r_out_rts && !out_rtr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_rts  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (r_pair_vld && (!r_out_rts || w_xfer)) begin
                r_out_data <= r_pair;
                r_out_rts  <= 1'b1;
            end else if (w_xfer) begin
                r_out_rts <= 1'b0;
            end
            // A fresh overflow wins over a simultaneous clear.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign out_data = r_out_data;
    assign out_rts  = r_out_rts;
    assign ovf      = r_ovf;

endmodule : i2s_rx_deser
`default_nettype wire
